// File: rtl/bram_stream_pkg.sv
// Shared types and helpers for the BRAM stream reader.
// Optional feature macro: BRAM_STREAM_LAST_EN (adds an end-of-transfer marker per word).
package bram_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int FIFO_DEPTH = 2;

    // Next word address; wraps to zero past the top of a 2**awidth space.
    function automatic logic [31:0] next_addr(input logic [31:0] addr, input int awidth);
        logic [31:0] mask;
        mask = (32'd1 << awidth) - 32'd1;
        return (addr + 32'd1) & mask;
    endfunction

endpackage

// File: rtl/bram_stream_if.sv
// Valid/ready word stream between the reader and the processing pipeline.
// With BRAM_STREAM_LAST_EN defined the stream also carries a last-word flag.
interface bram_stream_if #(
    parameter int DWIDTH = 32
);
    logic              valid;
    logic              ready;
    logic [DWIDTH-1:0] data;
`ifdef BRAM_STREAM_LAST_EN
    logic              last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
`else
    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
`endif
endinterface

// File: rtl/bram_stream_skid_fifo.sv
// Two-entry output buffer absorbing BRAM read latency under back-pressure.
// Head entry is presented directly from storage registers.
module bram_stream_skid_fifo
    import bram_stream_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             valid_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;

    // Occupancy update from push/pop.
    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign valid_o = (count_q != 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/bram_stream_reader.sv
// Reads LENGTH words from BASE through a 1-cycle-latency BRAM port onto a valid/ready stream.
// BRAM_STREAM_LAST_EN adds a per-word last flag on the stream interface.
module bram_stream_reader
    import bram_stream_pkg::*;
#(
    parameter int AWIDTH = 10,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AWIDTH-1:0] base_addr,
    input  logic [AWIDTH:0]   length,
    output logic              busy,
    output logic              done,
    output logic              bram_en,
    output logic [AWIDTH-1:0] bram_addr,
    input  logic [DWIDTH-1:0] bram_dout,
    bram_stream_if.master     m
);

`ifdef BRAM_STREAM_LAST_EN
    localparam int LAST_W = 1;
`else
    localparam int LAST_W = 0;
`endif
    localparam int FW = DWIDTH + LAST_W;

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] addr_q;
    logic [AWIDTH:0]   rem_q;
    logic              inflight_q;
    logic              busy_q;
    logic              done_q;
`ifdef BRAM_STREAM_LAST_EN
    logic              last_inflight_q;
`endif

    logic          fifo_valid_s;
    logic [1:0]    fifo_count_s;
    logic [FW-1:0] fifo_rdata_s;
    logic [FW-1:0] fifo_wdata_s;
    logic          pop_s;
    logic          room_s;
    logic          bram_en_s;
    logic          accept_s;
    logic          drain_done_s;
    logic          last_issue_s;

    assign pop_s        = fifo_valid_s && m.ready;
    // Words buffered plus the one in flight, net of this cycle's pop, must stay under two.
    assign room_s       = (({1'b0, fifo_count_s} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop_s}));
    assign accept_s     = (state_q == ST_IDLE) && start && !done_q;
    assign last_issue_s = bram_en_s && (rem_q == (AWIDTH+1)'(1));
    assign drain_done_s = (state_q == ST_DRAIN) && pop_s && (fifo_count_s == 2'd1) && !inflight_q;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s && (length != '0)) state_d = ST_READ;
                else                             state_d = ST_IDLE;
            end
            ST_READ: begin
                if (last_issue_s) state_d = ST_DRAIN;
                else              state_d = ST_READ;
            end
            ST_DRAIN: begin
                if (drain_done_s) state_d = ST_IDLE;
                else              state_d = ST_DRAIN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM output logic: read issue follows consumer readiness within the cycle.
    always_comb begin
        bram_en_s = 1'b0;
        if ((state_q == ST_READ) && room_s) bram_en_s = 1'b1;
        else                                bram_en_s = 1'b0;
    end

    // Address, remaining count, in-flight tracking and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q          <= '0;
            rem_q           <= '0;
            inflight_q      <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
`ifdef BRAM_STREAM_LAST_EN
            last_inflight_q <= 1'b0;
`endif
        end else begin
            inflight_q      <= bram_en_s;
`ifdef BRAM_STREAM_LAST_EN
            last_inflight_q <= last_issue_s;
`endif
            if (accept_s) begin
                addr_q <= base_addr;
                rem_q  <= length;
                busy_q <= (length != '0);
                done_q <= (length == '0);
            end else begin
                if (bram_en_s) begin
                    addr_q <= AWIDTH'(next_addr(32'(addr_q), AWIDTH));
                    rem_q  <= rem_q - (AWIDTH+1)'(1);
                end
                if (drain_done_s) busy_q <= 1'b0;
                done_q <= drain_done_s;
            end
        end
    end

`ifdef BRAM_STREAM_LAST_EN
    assign fifo_wdata_s = {last_inflight_q, bram_dout};
`else
    assign fifo_wdata_s = bram_dout;
`endif

    bram_stream_skid_fifo #(
        .WIDTH (FW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (inflight_q),
        .wdata_i (fifo_wdata_s),
        .pop_i   (pop_s),
        .rdata_o (fifo_rdata_s),
        .valid_o (fifo_valid_s),
        .count_o (fifo_count_s)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign bram_en   = bram_en_s;
    assign bram_addr = addr_q;
    assign m.valid   = fifo_valid_s;
    assign m.data    = fifo_rdata_s[DWIDTH-1:0];
`ifdef BRAM_STREAM_LAST_EN
    assign m.last    = fifo_valid_s && fifo_rdata_s[DWIDTH];
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed self-checking bench for bram_stream_reader with a behavioural 1-cycle BRAM.
module tb_bram_stream_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  base_addr = 10'd0;
    logic [10:0] length = 11'd0;
    logic        busy, done, bram_en;
    logic [9:0]  bram_addr;
    logic [31:0] bram_dout = 32'd0;

    int checks = 0;
    int failures = 0;

    bram_stream_if #(.DWIDTH(32)) sif();

    bram_stream_reader #(.AWIDTH(10), .DWIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .bram_en   (bram_en),
        .bram_addr (bram_addr),
        .bram_dout (bram_dout),
        .m         (sif)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_f(input int a);
        return 32'hD000_0000 | (32'(a) * 32'd3 + 32'd7);
    endfunction

    always @(posedge clk) begin
        if (bram_en) bram_dout <= mem_f(int'(bram_addr));
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_xfer(input int base, input int len, input bit rnd, input bit poke);
        int addrs[$];
        logic [31:0] words[$];
        bit lasts[$];
        int cyc, hs_cyc, done_cyc, issued, accepted, max_out, unstable;
        bit prev_stall;
        logic [31:0] prev_data;
        cyc = 1; hs_cyc = -1; done_cyc = -1; issued = 0; accepted = 0;
        max_out = 0; unstable = 0; prev_stall = 1'b0; prev_data = 32'd0;
        @(posedge clk); #1;
        start = 1'b1; base_addr = 10'(base); length = 11'(len); sif.ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        sif.ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        while (cyc < 200 && done_cyc < 0) begin
            @(negedge clk);
            if (prev_stall && sif.data !== prev_data) unstable++;
            if (bram_en) begin addrs.push_back(int'(bram_addr)); issued++; end
            if (sif.valid && sif.ready) begin
                words.push_back(sif.data);
`ifdef BRAM_STREAM_LAST_EN
                lasts.push_back(sif.last);
`endif
                accepted++; hs_cyc = cyc;
            end
            if (issued - accepted > max_out) max_out = issued - accepted;
            prev_stall = sif.valid && !sif.ready;
            prev_data = sif.data;
            if (done) done_cyc = cyc;
            else begin
                @(posedge clk); #1;
                start = poke && (cyc == 1);
                base_addr = poke ? 10'h300 : 10'(base);
                length = poke ? 11'd5 : 11'(len);
                sif.ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                cyc++;
            end
        end
        start = 1'b0;
        sif.ready = 1'b1;
        check_eq("done_seen", 64'(done_cyc >= 0), 64'd1);
        check_eq("hs_count", 64'(accepted), 64'(len));
        check_eq("rd_count", 64'(addrs.size()), 64'(len));
        check_eq("done_lat", 64'(done_cyc), 64'(hs_cyc + 1));
        check_eq("stall_stable", 64'(unstable), 64'd0);
        check_eq("outstanding_le2", 64'(max_out <= 2), 64'd1);
        for (int i = 0; i < len; i++) begin
            if (i < addrs.size()) check_eq("rd_addr", 64'(addrs[i]), 64'((base + i) % 1024));
            if (i < words.size()) check_eq("word", 64'(words[i]), 64'(mem_f((base + i) % 1024)));
`ifdef BRAM_STREAM_LAST_EN
            if (i < lasts.size()) check_eq("last_flag", 64'(lasts[i]), 64'(i == len - 1));
`endif
        end
    endtask

    initial begin
        sif.ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_en", 64'(bram_en), 64'd0);
        check_eq("rst_valid", 64'(sif.valid), 64'd0);
        check_eq("rst_addr", 64'(bram_addr), 64'd0);
        check_eq("rst_data", 64'(sif.data), 64'd0);

        // Cycle-exact timeline of a 4-word transfer with the consumer always ready.
        @(posedge clk); #1;
        start = 1'b1; base_addr = 10'h010; length = 11'd4; sif.ready = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1 start = 1'b0;
            @(negedge clk);
            check_eq("t1_en", 64'(bram_en), 64'(c <= 4));
            if (c <= 4) check_eq("t1_addr", 64'(bram_addr), 64'(16 + c - 1));
            check_eq("t1_valid", 64'(sif.valid), 64'(c >= 3 && c <= 6));
            if (c >= 3 && c <= 6) check_eq("t1_data", 64'(sif.data), 64'(mem_f(16 + c - 3)));
            check_eq("t1_busy", 64'(busy), 64'(c <= 6));
            check_eq("t1_done", 64'(done), 64'(c == 7));
        end

        do_xfer(10'h3FE, 4, 1'b0, 1'b0);
        do_xfer(10'h100, 16, 1'b1, 1'b0);
        do_xfer(10'h020, 4, 1'b0, 1'b1);

        // Empty transfer, with a start presented in its done cycle.
        @(posedge clk); #1;
        start = 1'b1; base_addr = 10'h055; length = 11'd0;
        @(posedge clk); #1;
        base_addr = 10'h077; length = 11'd5;
        @(negedge clk);
        check_eq("len0_done", 64'(done), 64'd1);
        check_eq("len0_busy", 64'(busy), 64'd0);
        check_eq("len0_en", 64'(bram_en), 64'd0);
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check_eq("len0_done_off", 64'(done), 64'd0);
        check_eq("len0_busy_off", 64'(busy), 64'd0);
        check_eq("len0_en_off", 64'(bram_en), 64'd0);

        // Asynchronous reset after five of ten words.
        begin
            int acc, cyc;
            acc = 0; cyc = 0;
            @(posedge clk); #1;
            start = 1'b1; base_addr = 10'h040; length = 11'd10; sif.ready = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            while (acc < 5 && cyc < 50) begin
                @(negedge clk);
                if (sif.valid && sif.ready) acc++;
                if (acc < 5) begin @(posedge clk); #1; end
                cyc++;
            end
            check_eq("rst_mid_reached", 64'(acc), 64'd5);
            #2 rst_n = 1'b0;
            #1;
            check_eq("mid_rst_busy", 64'(busy), 64'd0);
            check_eq("mid_rst_done", 64'(done), 64'd0);
            check_eq("mid_rst_en", 64'(bram_en), 64'd0);
            check_eq("mid_rst_valid", 64'(sif.valid), 64'd0);
            check_eq("mid_rst_addr", 64'(bram_addr), 64'd0);
            check_eq("mid_rst_data", 64'(sif.data), 64'd0);
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            do_xfer(0, 2, 1'b0, 1'b0);
        end

        do_xfer(10'h0A0, 3, 1'b0, 1'b0);
        do_xfer(10'h0B0, 1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
